// File: rtl/mem_hash_pkg.sv
// Shared types and constants for the mem_hash array generator and its job scheduler.
package mem_hash_pkg;

    localparam int unsigned ROW_ADDR_W = 6;
    // Stored job ids are this wide; the scheduler's ID_WIDTH must not exceed it.
    localparam int unsigned SLOT_ID_W  = 32;

    // ChaCha "expand 32-byte k" words that open every generator state.
    localparam logic [127:0] HASH_INIT = {32'h6b206574, 32'h79622d32, 32'h3320646e, 32'h61707865};

    function automatic int unsigned slot_tag_w(input int unsigned num_slots);
        return (num_slots > 1) ? $clog2(num_slots) : 1;
    endfunction

    typedef struct packed {
        logic                  busy;
        logic [SLOT_ID_W-1:0]  id;
        logic [ROW_ADDR_W-1:0] row;
    } slot_entry_t;

endpackage

// File: rtl/mem_gen_slot_alloc.sv
// Lowest-index free-slot picker for the mem_gen job scheduler.
module mem_gen_slot_alloc
    import mem_hash_pkg::*;
#(
    parameter int unsigned  NUM_SLOTS = 4,
    localparam int unsigned TAG_W     = slot_tag_w(NUM_SLOTS)
) (
    input  logic [NUM_SLOTS-1:0] busy,
    output logic [TAG_W-1:0]     free_tag,
    output logic                 none_free
);

    // Scan downwards so the lowest idle index wins.
    always_comb begin
        free_tag  = '0;
        none_free = 1'b1;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                free_tag  = TAG_W'(i);
                none_free = 1'b0;
            end
        end
    end

endmodule

// File: rtl/mem_gen_sched.sv
// Job scheduler for the interleaved mem_hash generator: slot allocation, launch, row tagging.
// Define MEM_GEN_SCHED_PERF_EN to add saturating perf_jobs / perf_stall counters.
module mem_gen_sched
    import mem_hash_pkg::*;
#(
    parameter int unsigned  N         = 32,
    parameter int unsigned  ROWS      = 64,
    parameter int unsigned  NUM_SLOTS = 4,
    parameter int unsigned  ID_WIDTH  = 32,
    localparam int unsigned TAG_W     = slot_tag_w(NUM_SLOTS),
    localparam int unsigned KW        = 16 * N
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  job_valid,
    output logic                  job_ready,
    input  logic [KW-1:0]         job_key,
    input  logic [ID_WIDTH-1:0]   job_id,
    output logic                  eng_start,
    output logic [KW-1:0]         eng_key,
    output logic [TAG_W-1:0]      eng_tag,
    input  logic                  eng_accept,
    input  logic                  eng_out_valid,
    input  logic [TAG_W-1:0]      eng_out_tag,
    input  logic [KW-1:0]         eng_out_data,
    output logic                  eng_hold,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [KW-1:0]         out_data,
    output logic [ROW_ADDR_W-1:0] out_addr,
    output logic [ID_WIDTH-1:0]   out_id,
    output logic                  job_done,
    output logic                  tag_err
`ifdef MEM_GEN_SCHED_PERF_EN
    ,
    output logic [31:0]           perf_jobs,
    output logic [31:0]           perf_stall
`endif
);

    typedef enum logic [0:0] {StIdle, StLaunch} launch_st_e;

    // ROWS is a power of two, so this doubles as the wrap mask.
    localparam logic [ROW_ADDR_W-1:0] LAST_ROW = ROW_ADDR_W'(ROWS - 1);

    slot_entry_t          slot_q [NUM_SLOTS];
    slot_entry_t          slot_d [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] busy;
    logic [TAG_W-1:0]     free_tag;
    logic                 none_free;

    launch_st_e           st_q, st_d;
    logic [KW-1:0]        key_q;
    logic [TAG_W-1:0]     ltag_q;

    logic                  out_valid_q;
    logic [KW-1:0]         out_data_q;
    logic [ROW_ADDR_W-1:0] out_addr_q;
    logic [ID_WIDTH-1:0]   out_id_q;
    logic [TAG_W-1:0]      out_tag_q;
    logic                  tag_err_q;

    logic job_acc, row_take, row_hit, out_acc, retire;

    always_comb begin
        for (int i = 0; i < NUM_SLOTS; i++) busy[i] = slot_q[i].busy;
    end

    mem_gen_slot_alloc #(
        .NUM_SLOTS (NUM_SLOTS)
    ) u_alloc (
        .busy      (busy),
        .free_tag  (free_tag),
        .none_free (none_free)
    );

    assign eng_hold  = out_valid_q && !out_ready;
    assign job_ready = !none_free && (st_q == StIdle);
    assign job_acc   = job_valid && job_ready;
    assign row_take  = eng_out_valid && !eng_hold;
    assign row_hit   = row_take && slot_q[eng_out_tag].busy;
    assign out_acc   = out_valid_q && out_ready;
    assign retire    = out_acc && (out_addr_q == LAST_ROW);

    always_comb begin
        st_d = st_q;
        unique case (st_q)
            StIdle:   if (job_acc) st_d = StLaunch;
            StLaunch: if (eng_accept && !eng_hold) st_d = StIdle;
            default:  st_d = StIdle;
        endcase
    end

    // Allocation only targets an idle slot, so it never collides with the retiring one.
    always_comb begin
        for (int i = 0; i < NUM_SLOTS; i++) slot_d[i] = slot_q[i];
        if (row_hit) begin
            slot_d[eng_out_tag].row = (slot_q[eng_out_tag].row + 1'b1) & LAST_ROW;
        end
        if (retire) slot_d[out_tag_q].busy = 1'b0;
        if (job_acc) begin
            slot_d[free_tag] = '{busy: 1'b1, id: SLOT_ID_W'(job_id), row: '0};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st_q        <= StIdle;
            key_q       <= '0;
            ltag_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_addr_q  <= '0;
            out_id_q    <= '0;
            out_tag_q   <= '0;
            tag_err_q   <= 1'b0;
            for (int i = 0; i < NUM_SLOTS; i++) slot_q[i] <= '0;
        end else begin
            st_q <= st_d;
            for (int i = 0; i < NUM_SLOTS; i++) slot_q[i] <= slot_d[i];
            if (job_acc) begin
                key_q  <= job_key;
                ltag_q <= free_tag;
            end
            if (!eng_hold) begin
                out_valid_q <= row_hit;
                if (row_hit) begin
                    out_data_q <= eng_out_data;
                    out_addr_q <= slot_q[eng_out_tag].row;
                    out_id_q   <= ID_WIDTH'(slot_q[eng_out_tag].id);
                    out_tag_q  <= eng_out_tag;
                end
            end
            if (row_take && !slot_q[eng_out_tag].busy) tag_err_q <= 1'b1;
        end
    end

    assign eng_start = (st_q == StLaunch);
    assign eng_key   = key_q;
    assign eng_tag   = ltag_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_addr  = out_addr_q;
    assign out_id    = out_id_q;
    assign job_done  = retire;
    assign tag_err   = tag_err_q;

`ifdef MEM_GEN_SCHED_PERF_EN
    logic [31:0] perf_jobs_q, perf_stall_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_jobs_q  <= '0;
            perf_stall_q <= '0;
        end else begin
            if (retire && (perf_jobs_q != '1)) perf_jobs_q <= perf_jobs_q + 32'd1;
            if (eng_hold && (perf_stall_q != '1)) perf_stall_q <= perf_stall_q + 32'd1;
        end
    end

    assign perf_jobs  = perf_jobs_q;
    assign perf_stall = perf_stall_q;
`else
    // No counters in this build.
`endif

endmodule

// File: tb/tb_mem_gen_sched.sv
// Self-checking bench for mem_gen_sched: randomized engine/sink against a job-level model.
module tb_mem_gen_sched;

    localparam int unsigned N         = 32;
    localparam int unsigned ROWS      = 64;
    localparam int unsigned NUM_SLOTS = 4;
    localparam int unsigned ID_WIDTH  = 32;
    localparam int unsigned TAG_W     = 2;
    localparam int unsigned KW        = 16 * N;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                job_valid;
    logic                job_ready;
    logic [KW-1:0]       job_key;
    logic [ID_WIDTH-1:0] job_id;
    logic                eng_start;
    logic [KW-1:0]       eng_key;
    logic [TAG_W-1:0]    eng_tag;
    logic                eng_accept;
    logic                eng_out_valid;
    logic [TAG_W-1:0]    eng_out_tag;
    logic [KW-1:0]       eng_out_data;
    logic                eng_hold;
    logic                out_valid;
    logic                out_ready;
    logic [KW-1:0]       out_data;
    logic [5:0]          out_addr;
    logic [ID_WIDTH-1:0] out_id;
    logic                job_done;
    logic                tag_err;
`ifdef MEM_GEN_SCHED_PERF_EN
    logic [31:0]         perf_jobs;
    logic [31:0]         perf_stall;
`endif

    mem_gen_sched #(
        .N         (N),
        .ROWS      (ROWS),
        .NUM_SLOTS (NUM_SLOTS),
        .ID_WIDTH  (ID_WIDTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .job_valid     (job_valid),
        .job_ready     (job_ready),
        .job_key       (job_key),
        .job_id        (job_id),
        .eng_start     (eng_start),
        .eng_key       (eng_key),
        .eng_tag       (eng_tag),
        .eng_accept    (eng_accept),
        .eng_out_valid (eng_out_valid),
        .eng_out_tag   (eng_out_tag),
        .eng_out_data  (eng_out_data),
        .eng_hold      (eng_hold),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_addr      (out_addr),
        .out_id        (out_id),
        .job_done      (job_done),
        .tag_err       (tag_err)
`ifdef MEM_GEN_SCHED_PERF_EN
        ,
        .perf_jobs     (perf_jobs),
        .perf_stall    (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [KW-1:0]       key;
        logic [ID_WIDTH-1:0] id;
    } job_t;

    typedef struct {
        logic [ID_WIDTH-1:0] id;
        int                  addr;
        logic [KW-1:0]       data;
        int                  tag;
    } row_t;

    int total = 0;
    int bad   = 0;

    // Job-level model: which tags hold a job, the launch waiting on the engine, rows in flight.
    job_t                jobs_q[$];
    row_t                pend[$];
    bit                  m_busy [NUM_SLOTS];
    logic [ID_WIDTH-1:0] m_id   [NUM_SLOTS];
    logic [KW-1:0]       m_key  [NUM_SLOTS];
    bit                  m_launch;
    int                  m_ltag;
    bit                  m_err;

    // Engine stand-in: rows still owed per tag and the row currently presented.
    bit            e_run  [NUM_SLOTS];
    int            e_next [NUM_SLOTS];
    bit            pres;
    int            pres_tag;
    int            pres_row;
    logic [KW-1:0] pres_data;
    bit            inject_bogus;
    int            bogus_tag;

    int acc_mode;
    int acc_hold;
    int rdy_mode;
    int rdy_phase;
    int row_pct;

    task automatic chk(input string name, input logic [KW-1:0] obs, input logic [KW-1:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    function automatic logic [KW-1:0] rand_vec();
        logic [KW-1:0] v;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic bit model_idle();
        bit any = 1'b0;
        for (int t = 0; t < NUM_SLOTS; t++) if (m_busy[t] || e_run[t]) any = 1'b1;
        return !any && !m_launch && !pres && (pend.size() == 0) && (jobs_q.size() == 0);
    endfunction

    task automatic model_clear();
        pend.delete();
        jobs_q.delete();
        for (int t = 0; t < NUM_SLOTS; t++) begin
            m_busy[t] = 1'b0;
            e_run[t]  = 1'b0;
            e_next[t] = 0;
        end
        m_launch     = 1'b0;
        m_err        = 1'b0;
        pres         = 1'b0;
        inject_bogus = 1'b0;
        acc_hold     = 0;
    endtask

    task automatic drive_inputs();
        int cand[$];
        job_valid = (jobs_q.size() != 0);
        job_key   = job_valid ? jobs_q[0].key : '0;
        job_id    = job_valid ? jobs_q[0].id : '0;
        case (acc_mode)
            0: eng_accept = 1'b1;
            1: eng_accept = ($urandom_range(0, 1) == 1);
            default: begin
                eng_accept = !(m_launch && acc_hold > 0);
                if (m_launch && acc_hold > 0) acc_hold--;
            end
        endcase
        case (rdy_mode)
            0: out_ready = 1'b1;
            1: begin
                out_ready = (rdy_phase < 3);
                rdy_phase = (rdy_phase + 1) % 6;
            end
            default: out_ready = ($urandom_range(0, 3) != 0);
        endcase
        // A presented row stays put until the scheduler takes it (engine frozen by eng_hold).
        if (!pres) begin
            if (inject_bogus) begin
                pres         = 1'b1;
                pres_tag     = bogus_tag;
                pres_row     = -1;
                pres_data    = rand_vec();
                inject_bogus = 1'b0;
            end else if ($urandom_range(1, 100) <= row_pct) begin
                for (int t = 0; t < NUM_SLOTS; t++) if (e_run[t]) cand.push_back(t);
                if (cand.size() != 0) begin
                    pres_tag  = cand[$urandom_range(0, cand.size() - 1)];
                    pres_row  = e_next[pres_tag];
                    pres_data = rand_vec();
                    pres      = 1'b1;
                end
            end
        end
        eng_out_valid = pres;
        eng_out_tag   = TAG_W'(pres_tag);
        eng_out_data  = pres ? pres_data : '0;
    endtask

    // One clock: check outputs mid-cycle, advance the model across the edge, drive next inputs.
    task automatic cycle();
        bit   hold_e, out_acc, done_e, rdy_e, job_acc, launch_acc, eng_cons;
        int   nbusy, ftag;
        row_t r;
        #2;
        nbusy = 0;
        ftag  = 0;
        for (int t = NUM_SLOTS - 1; t >= 0; t--) begin
            if (m_busy[t]) nbusy++;
            else ftag = t;
        end
        rdy_e   = (nbusy < NUM_SLOTS) && !m_launch;
        hold_e  = (pend.size() != 0) && !out_ready;
        out_acc = (pend.size() != 0) && out_ready;
        done_e  = 1'b0;
        if (out_acc) done_e = (pend[0].addr == ROWS - 1);

        chk("out_valid", out_valid, pend.size() != 0);
        chk("eng_hold", eng_hold, hold_e);
        chk("job_ready", job_ready, rdy_e);
        chk("eng_start", eng_start, m_launch);
        chk("tag_err", tag_err, m_err);
        chk("job_done", job_done, done_e);
        if (m_launch) begin
            chk("eng_key", eng_key, m_key[m_ltag]);
            chk("eng_tag", eng_tag, m_ltag);
        end
        if (pend.size() != 0) begin
            chk("out_id", out_id, pend[0].id);
            chk("out_addr", out_addr, pend[0].addr);
            chk("out_data", out_data, pend[0].data);
        end

        job_acc    = job_valid && rdy_e;
        launch_acc = m_launch && eng_accept && !hold_e;
        eng_cons   = pres && !hold_e;
        if (eng_cons) begin
            if (m_busy[pres_tag]) begin
                r.id   = m_id[pres_tag];
                r.addr = pres_row;
                r.data = pres_data;
                r.tag  = pres_tag;
                pend.push_back(r);
            end else begin
                m_err = 1'b1;
            end
            if (pres_row >= 0) begin
                e_next[pres_tag]++;
                if (e_next[pres_tag] == ROWS) e_run[pres_tag] = 1'b0;
            end
            pres = 1'b0;
        end
        if (out_acc) begin
            r = pend.pop_front();
            if (r.addr == ROWS - 1) m_busy[r.tag] = 1'b0;
        end
        if (launch_acc) begin
            e_run[m_ltag]  = 1'b1;
            e_next[m_ltag] = 0;
            m_launch       = 1'b0;
        end
        if (job_acc) begin
            m_busy[ftag] = 1'b1;
            m_id[ftag]   = job_id;
            m_key[ftag]  = job_key;
            m_ltag       = ftag;
            m_launch     = 1'b1;
            void'(jobs_q.pop_front());
        end

        @(posedge clk);
        #1;
        drive_inputs();
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        job_valid     = 1'b0;
        eng_accept    = 1'b0;
        eng_out_valid = 1'b0;
        out_ready     = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_clear();
        drive_inputs();
    endtask

    task automatic drain(input int max_cyc, input string name);
        int n = 0;
        bit idle;
        idle = model_idle();
        while (!idle && n < max_cyc) begin
            cycle();
            n++;
            idle = model_idle();
        end
        chk(name, idle, 1'b1);
    endtask

    task automatic add_job(input logic [KW-1:0] key, input logic [ID_WIDTH-1:0] id);
        job_t j;
        j.key = key;
        j.id  = id;
        jobs_q.push_back(j);
    endtask

    initial begin
        logic [KW-1:0] a5_key;
        int            n;
        rst_n         = 1'b0;
        job_valid     = 1'b0;
        job_key       = '0;
        job_id        = '0;
        eng_accept    = 1'b0;
        eng_out_valid = 1'b0;
        eng_out_tag   = '0;
        eng_out_data  = '0;
        out_ready     = 1'b1;
        acc_mode      = 0;
        rdy_mode      = 0;
        rdy_phase     = 0;
        row_pct       = 100;
        pres_tag      = 0;
        pres_row      = 0;
        m_ltag        = 0;
        bogus_tag     = 0;

        // Reset state
        do_reset();
        repeat (2) cycle();

        // Single job, immediate accept, sink always ready
        for (int i = 0; i < KW / 8; i++) a5_key[i*8 +: 8] = 8'hA5;
        add_job(a5_key, 32'h1234);
        drain(300, "single_job_drain");

        // Five jobs back to back; the fifth waits for the first retire
        row_pct = 70;
        for (int i = 0; i < 5; i++) add_job(rand_vec(), $urandom);
        drain(2000, "five_jobs_drain");

        // Sink toggles ready every three cycles with interleaved rows
        rdy_mode  = 1;
        rdy_phase = 0;
        row_pct   = 90;
        for (int i = 0; i < 4; i++) add_job(rand_vec(), $urandom);
        drain(4000, "toggle_ready_drain");
        rdy_mode = 0;

        // Engine withholds accept for five cycles while a second job is offered
        acc_mode = 2;
        acc_hold = 5;
        add_job(rand_vec(), 32'hCAFE0001);
        add_job(rand_vec(), 32'hCAFE0002);
        drain(1000, "accept_delay_drain");
        acc_mode = 0;

        // Row for idle slot 2 is dropped and sets the sticky error
        inject_bogus = 1'b1;
        bogus_tag    = 2;
        repeat (4) cycle();
        add_job(rand_vec(), 32'h0BAD0002);
        drain(300, "after_tag_err_drain");

        // Reset in the middle of a job, then restart from row 0
        row_pct = 100;
        add_job(rand_vec(), 32'h0000D00D);
        n = 0;
        while (e_next[0] < 20 && n < 200) begin
            cycle();
            n++;
        end
        chk("reach_row20", e_next[0] >= 20, 1'b1);
        do_reset();
        repeat (2) cycle();
        add_job(rand_vec(), 32'h0000BEEF);
        drain(300, "post_reset_drain");

        // Mixed random traffic
        acc_mode = 1;
        rdy_mode = 2;
        row_pct  = 60;
        for (int i = 0; i < 10; i++) add_job(rand_vec(), $urandom);
        drain(6000, "random_mix_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_gen_sched.md
Name: mem_gen_sched

Overview:
Job scheduler in front of the mem_hash ChaCha memory-array generator.
- Accepts seed jobs (key + job id) from upstream.
- Allocates each job one of NUM_SLOTS interleave slots in the 4-block pipelined engine and launches it.
- Tags every engine output row with its job id and row address, and forwards it downstream with backpressure.
- Retires the slot and pulses job_done after the last row.

Parameters:
- N, 32, word width in bits; key and row are 16*N bits.
- ROWS, 64, rows produced per job; must be a power of two ≤ 64.
- NUM_SLOTS, 4, concurrent jobs; power of two, 2..8.
- ID_WIDTH, 32, job id width.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- job_valid  in  1  upstream job offered
- job_ready  out  1  scheduler can accept a job
- job_key  in  16*N  seed key
- job_id  in  ID_WIDTH  job identifier
- eng_start  out  1  launch seed into engine
- eng_key  out  16*N  key for launched job
- eng_tag  out  clog2(NUM_SLOTS)  slot tag for launched job
- eng_accept  in  1  engine took eng_start this cycle
- eng_out_valid  in  1  engine row valid
- eng_out_tag  in  clog2(NUM_SLOTS)  slot tag of engine row
- eng_out_data  in  16*N  engine row data
- eng_hold  out  1  freeze engine (drives its clock enable low)
- out_valid  out  1  row valid downstream
- out_ready  in  1  downstream accepts row
- out_data  out  16*N  row data
- out_addr  out  6  row index within job
- out_id  out  ID_WIDTH  job id of row
- job_done  out  1  one-cycle pulse: last row of out_id accepted
- tag_err  out  1  sticky: row arrived for an idle slot

Behaviour:
- Reset: rst_n is synchronous, active-low, on clock clk. Reset clears all slots to idle, the launch register, the output register and tag_err.
  - Reset outputs: job_ready=1, eng_start=0, eng_hold=0, out_valid=0, job_done=0, tag_err=0.
  - Reset mid-job: all in-flight state is discarded. The engine shares rst_n.
- Slot table, one entry per slot: busy bit, id, 6-bit row counter.
- Allocation:
  - job_ready = some slot idle AND launch register empty.
  - On job_valid && job_ready, select the lowest-index idle slot and store id. Set busy, clear the row count, load the launch register.
  - eng_start is asserted the next cycle and held until eng_accept, so start-to-accept latency is ≥ 1 cycle.
  - While eng_start is asserted and not accepted, job_ready = 0.
- Launch FSM:
  - IDLE → LAUNCH on job accept.
  - LAUNCH → IDLE on eng_accept && !eng_hold.
- Rows:
  - When eng_out_valid && !eng_hold and the slot is busy: out_data, out_addr = row count, out_id = slot id. Registered; out_valid is asserted 1 cycle later.
  - Row count increments modulo ROWS.
  - Row for an idle slot: row dropped, tag_err set.
- Backpressure:
  - eng_hold = out_valid && !out_ready. The output register holds and the engine is frozen, so no row is lost.
  - Holding rows in the engine also suppresses eng_accept.
- Retire:
  - When the row with out_addr = ROWS-1 is accepted (out_valid && out_ready), pulse job_done with out_id.
  - Clear busy in that cycle.
  - The freed slot is visible to allocation the following cycle. No same-cycle free+alloc of the same slot.
- Simultaneous job accept and row retire on different slots are both honoured.
- All slots busy: job_ready = 0. Rows continue to drain.

Optional Feature:
- Macro: MEM_GEN_SCHED_PERF_EN.
- Defined: adds 32-bit output ports perf_jobs (jobs retired) and perf_stall (cycles eng_hold = 1). Both counters saturate at all-ones and clear on reset.
- Undefined: no ports, no counters. Behaviour is otherwise identical.

Decomposition:
- Shared package mem_hash_pkg holds:
  - slot_tag_t width function;
  - ROW_ADDR_W = 6;
  - the slot entry struct {busy, id, row};
  - the hash_init constant vector, shared with the generator.
- One natural sub-module, mem_gen_slot_alloc:
  - lowest-index free-slot priority encoder plus a "none free" flag;
  - combinational, parameterised by NUM_SLOTS.

Test Plan:
- Single job, key=all 0xA5, id=0x1234, eng_accept immediate, out_ready=1 → 64 rows with out_addr 0..63 and out_id=0x1234; job_done pulses with row 63; job_ready returns high.
- 5 jobs back-to-back, NUM_SLOTS=4 → jobs 0-3 take tags 0,1,2,3; job_ready=0 until first retire; job 4 gets the freed tag no earlier than the cycle after job_done.
- out_ready toggled 1/0 every 3 cycles during interleaved rows → eng_hold tracks out_valid && !out_ready; no row lost or duplicated; per-id addr sequence strictly 0..63.
- eng_accept held low 5 cycles → eng_start, eng_key and eng_tag stable for those 5 cycles; job_ready=0 throughout.
- Row injected with eng_out_tag=2 while slot 2 idle → no out_valid; tag_err=1 and stays 1 until reset.
- rst_n low one cycle mid-job (row 20) → next cycle: out_valid=0, job_ready=1, all slots idle, tag_err=0; a new job restarts at addr 0.
